// File: rtl/transpose_a_stream_buffer.sv
`default_nettype none
// ==========================================================================
// transpose_a_stream_buffer : ping-pong buffer, row-major A in, column-major
// A out. Optional mat_count port with XPOSE_COUNT_EN.  Rev 1.0
// ==========================================================================
module transpose_a_stream_buffer #(
   parameter int DATA_W = 32,
   parameter int ROWS   = 4,
   parameter int COLS   = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              valid_in,
   output logic              ready_in,
   input  logic [DATA_W-1:0] data_in,
   output logic              valid_out,
   input  logic              ready_out,
   output logic [DATA_W-1:0] data_out,
   output logic              last_out
`ifdef XPOSE_COUNT_EN
   ,
   output logic [15:0]       mat_count
`endif
);

   localparam int DEPTH = ROWS * COLS;
   localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;
   localparam int COL_W = (COLS > 1) ? $clog2(COLS) : 1;
   localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(ROWS - 1);
   localparam logic [COL_W-1:0] COL_LAST = COL_W'(COLS - 1);

   logic [DATA_W-1:0] mem_q [2][DEPTH];

   logic [1:0]       full_q, full_d;
   logic             w_sel_q, w_sel_d;
   logic             r_sel_q, r_sel_d;
   logic [ROW_W-1:0] wr_row_q, wr_row_d, rd_row_q, rd_row_d;
   logic [COL_W-1:0] wr_col_q, wr_col_d, rd_col_q, rd_col_d;

   logic             wr_fire, rd_fire, wr_done, rd_done;
   logic [IDX_W-1:0] wr_idx, rd_idx;

   always_comb begin
      // Gating with rst keeps ready_in low for the whole reset pulse.
      ready_in  = !rst && !full_q[w_sel_q];
      valid_out = full_q[r_sel_q];
      wr_fire   = valid_in && ready_in;
      rd_fire   = valid_out && ready_out;
      wr_done   = wr_fire && (wr_row_q == ROW_LAST) && (wr_col_q == COL_LAST);
      rd_done   = rd_fire && (rd_row_q == ROW_LAST) && (rd_col_q == COL_LAST);
      wr_idx    = IDX_W'(int'(wr_row_q) * COLS + int'(wr_col_q));
      rd_idx    = IDX_W'(int'(rd_row_q) * COLS + int'(rd_col_q));
      data_out  = valid_out ? mem_q[r_sel_q][rd_idx] : '0;
      last_out  = valid_out && (rd_row_q == ROW_LAST) && (rd_col_q == COL_LAST);
   end

   always_comb begin
      wr_row_d = wr_row_q;
      wr_col_d = wr_col_q;
      rd_row_d = rd_row_q;
      rd_col_d = rd_col_q;
      w_sel_d  = w_sel_q ^ wr_done;
      r_sel_d  = r_sel_q ^ rd_done;
      full_d   = full_q;

      if (wr_fire) begin
         if (wr_col_q == COL_LAST) begin
            wr_col_d = '0;
            wr_row_d = (wr_row_q == ROW_LAST) ? '0 : wr_row_q + ROW_W'(1);
         end else begin
            wr_col_d = wr_col_q + COL_W'(1);
         end
      end

      // Row is the inner index on the read side: this produces column-major order.
      if (rd_fire) begin
         if (rd_row_q == ROW_LAST) begin
            rd_row_d = '0;
            rd_col_d = (rd_col_q == COL_LAST) ? '0 : rd_col_q + COL_W'(1);
         end else begin
            rd_row_d = rd_row_q + ROW_W'(1);
         end
      end

      // Completions always target different banks, so both updates apply.
      if (wr_done) full_d[w_sel_q] = 1'b1;
      if (rd_done) full_d[r_sel_q] = 1'b0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         full_q   <= '0;
         w_sel_q  <= 1'b0;
         r_sel_q  <= 1'b0;
         wr_row_q <= '0;
         wr_col_q <= '0;
         rd_row_q <= '0;
         rd_col_q <= '0;
         for (int b = 0; b < 2; b++) begin
            for (int i = 0; i < DEPTH; i++) begin
               mem_q[b][i] <= '0;
            end
         end
      end else begin
         full_q   <= full_d;
         w_sel_q  <= w_sel_d;
         r_sel_q  <= r_sel_d;
         wr_row_q <= wr_row_d;
         wr_col_q <= wr_col_d;
         rd_row_q <= rd_row_d;
         rd_col_q <= rd_col_d;
         if (wr_fire) mem_q[w_sel_q][wr_idx] <= data_in;
      end
   end

`ifdef XPOSE_COUNT_EN
   logic [15:0] mat_count_q, mat_count_d;

   always_comb begin
      mat_count_d = mat_count_q + {15'd0, (rd_fire && last_out)};
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) mat_count_q <= '0;
      else     mat_count_q <= mat_count_d;
   end

   assign mat_count = mat_count_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_transpose_a_stream_buffer.sv
`default_nettype none
// ==========================================================================
// tb_transpose_a_stream_buffer : directed bench, 2x3 matrices.  Rev 1.0
// ==========================================================================
module tb_transpose_a_stream_buffer;

   localparam int DATA_W = 32;
   localparam int ROWS   = 2;
   localparam int COLS   = 3;
   localparam int DEPTH  = ROWS * COLS;

   logic              clk = 1'b0;
   logic              rst;
   logic              valid_in;
   logic              ready_in;
   logic [DATA_W-1:0] data_in;
   logic              valid_out;
   logic              ready_out;
   logic [DATA_W-1:0] data_out;
   logic              last_out;
`ifdef XPOSE_COUNT_EN
   logic [15:0]       mat_count;
`endif

   int checks   = 0;
   int failures = 0;

   int t1exp [DEPTH];
   int vin  [16];
   int vexp [16];

   transpose_a_stream_buffer #(
      .DATA_W (DATA_W),
      .ROWS   (ROWS),
      .COLS   (COLS)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .valid_in  (valid_in),
      .ready_in  (ready_in),
      .data_in   (data_in),
      .valid_out (valid_out),
      .ready_out (ready_out),
      .data_out  (data_out),
      .last_out  (last_out)
`ifdef XPOSE_COUNT_EN
      ,
      .mat_count (mat_count)
`endif
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Feeds vin[0..n_in-1] with ready_out high and checks outputs against vexp.
   task automatic stream(input int n_in, input int n_out, input string tag);
      int  ii = 0;
      int  oo = 0;
      logic acc;
      ready_out = 1'b1;
      for (int cyc = 0; cyc < 60 && (ii < n_in || oo < n_out); cyc++) begin
         valid_in = (ii < n_in);
         data_in  = valid_in ? DATA_W'(vin[ii]) : '0;
         if (valid_in) check({tag, "_no_stall"}, ready_in, 1);
         if (valid_out) begin
            if (oo < n_out) begin
               check({tag, "_data"}, data_out, vexp[oo]);
               check({tag, "_last"}, last_out, ((oo % DEPTH) == DEPTH - 1) ? 1 : 0);
               oo++;
            end else begin
               check({tag, "_extra_out"}, valid_out, 0);
            end
         end
         acc = valid_in && ready_in;
         tick();
         if (acc) ii++;
      end
      valid_in = 1'b0;
      check({tag, "_in_count"}, ii, n_in);
      check({tag, "_out_count"}, oo, n_out);
   endtask

   initial begin
      int   acc_cnt;
      int   oo;
      logic a;

      t1exp = '{1, 4, 2, 5, 3, 6};
      rst = 1'b1; valid_in = 1'b0; data_in = '0; ready_out = 1'b0;

      // Reset state
      @(posedge clk); @(posedge clk); #1;
      check("rst_ready_in", ready_in, 0);
      check("rst_valid_out", valid_out, 0);
      check("rst_data_out", data_out, 0);
      check("rst_last_out", last_out, 0);
`ifdef XPOSE_COUNT_EN
      check("rst_mat_count", mat_count, 0);
`endif
      @(negedge clk); rst = 1'b0; #1;
      check("rel_ready_in", ready_in, 1);
      tick();

      // Test 1: single matrix, latency and ordering
      ready_out = 1'b1;
      for (int i = 0; i < DEPTH; i++) begin
         valid_in = 1'b1; data_in = DATA_W'(i + 1);
         check("t1_valid_early", valid_out, 0);
         tick();
      end
      valid_in = 1'b0;
      check("t1_latency", valid_out, 1);
      for (int k = 0; k < DEPTH; k++) begin
         check("t1_data", data_out, t1exp[k]);
         check("t1_last", last_out, (k == DEPTH - 1) ? 1 : 0);
         tick();
      end
      check("t1_idle", valid_out, 0);

      // Test 2: back-to-back matrices
      for (int i = 0; i < DEPTH; i++) begin
         vin[i]          = i + 1;
         vin[i + DEPTH]  = i + 11;
         vexp[i]         = t1exp[i];
         vexp[i + DEPTH] = t1exp[i] + 10;
      end
      stream(12, 12, "t2");

      // Test 3: output stalled, three matrices offered
      ready_out = 1'b0;
      acc_cnt = 0;
      for (int cyc = 0; cyc < 20; cyc++) begin
         valid_in = 1'b1;
         data_in  = (acc_cnt < 6)  ? DATA_W'(1 + acc_cnt) :
                    (acc_cnt < 12) ? DATA_W'(5 + acc_cnt) : DATA_W'(9 + acc_cnt);
         if (acc_cnt == 12) check("t3_blocked", ready_in, 0);
         if (valid_out) check("t3_hold", data_out, 1);
         a = ready_in;
         tick();
         if (a) acc_cnt++;
      end
      check("t3_accepted", acc_cnt, 12);
      ready_out = 1'b1;
      for (int k = 0; k < DEPTH; k++) begin
         check("t3_ready_low", ready_in, 0);
         check("t3_drain1", data_out, t1exp[k]);
         tick();
      end
      check("t3_ready_back", ready_in, 1);
      valid_in = 1'b0;
      for (int k = 0; k < DEPTH; k++) begin
         check("t3_drain2", data_out, t1exp[k] + 10);
         tick();
      end
      check("t3_idle", valid_out, 0);

      // Test 4: ready_out toggling during drain
      ready_out = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         valid_in = 1'b1; data_in = DATA_W'(31 + i);
         tick();
      end
      valid_in = 1'b0;
      oo = 0;
      for (int cyc = 0; cyc < 20 && oo < DEPTH; cyc++) begin
         ready_out = (cyc % 2 == 0);
         check("t4_valid", valid_out, 1);
         check("t4_data", data_out, t1exp[oo] + 30);
         check("t4_last", last_out, (oo == DEPTH - 1) ? 1 : 0);
         a = ready_out;
         tick();
         if (a) oo++;
      end
      check("t4_count", oo, DEPTH);
      check("t4_idle", valid_out, 0);

      // Test 5: reset while one matrix is full and another is partial
      ready_out = 1'b0;
      for (int i = 0; i < DEPTH + 3; i++) begin
         valid_in = 1'b1;
         data_in  = (i < DEPTH) ? DATA_W'(41 + i) : DATA_W'(i - DEPTH + 1);
         tick();
      end
      valid_in = 1'b0;
      check("t5_pre_valid", valid_out, 1);
      #2 rst = 1'b1;
      #1;
      check("t5_rst_valid", valid_out, 0);
      check("t5_rst_data", data_out, 0);
      check("t5_rst_last", last_out, 0);
      check("t5_rst_ready", ready_in, 0);
`ifdef XPOSE_COUNT_EN
      check("t5_rst_count", mat_count, 0);
`endif
      tick();
      @(negedge clk); rst = 1'b0;
      tick();
      check("t5_ready_after", ready_in, 1);
      check("t5_valid_after", valid_out, 0);
      for (int i = 0; i < DEPTH; i++) begin
         vin[i]  = 7 + i;
         vexp[i] = t1exp[i] + 6;
      end
      stream(6, 6, "t5");
`ifdef XPOSE_COUNT_EN
      check("t5_mat_count", mat_count, 1);

      // Test 6: mat_count wrap
      ready_out = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         valid_in = 1'b1; data_in = DATA_W'(51 + i);
         tick();
      end
      valid_in = 1'b0;
      force dut.mat_count_q = 16'hFFFF;
      #1;
      release dut.mat_count_q;
      check("t6_preload", mat_count, 16'hFFFF);
      ready_out = 1'b1;
      for (int k = 0; k < DEPTH; k++) begin
         check("t6_data", data_out, t1exp[k] + 50);
         tick();
      end
      check("t6_wrap", mat_count, 0);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/transpose_a_stream_buffer.md
# transpose_a_stream_buffer

Streaming ping-pong buffer that sits directly upstream of the transposed-A matmul stage. It accepts matrix A one element per beat in row-major order and re-emits the same matrix in column-major order, so the matmul core consumes A^T as a plain row-major stream. Two banks let one matrix be written while the previous one drains, which sustains one element per cycle.

## Interface
- DATA_W, 32, element width in bits (matches the 32-bit matmul operand ports)
- ROWS, 4, rows of the input matrix A (R)
- COLS, 4, columns of the input matrix A (C)

Ports:
- clk  in  1  sole clock; all state updates on the rising edge
- rst  in  1  asynchronous, active-high reset
- valid_in  in  1  input element valid
- ready_in  out  1  buffer can accept an element this cycle
- data_in  in  DATA_W  element of A, row-major order
- valid_out  out  1  output element valid
- ready_out  in  1  downstream matmul accepts the element
- data_out  out  DATA_W  element of A^T, row-major order (A column-major)
- last_out  out  1  high on the final element (R*C-th) of each output matrix
- mat_count  out  16  completed output matrices; present only with XPOSE_COUNT_EN

## Operation
- Storage: two banks, each holding R*C words. Per-bank full flag; write-bank select w_sel; read-bank select r_sel.
- Write side:
  - Counters wr_row (0..R-1) and wr_col (0..C-1).
  - An element is accepted when valid_in && ready_in. It is stored at bank[w_sel][wr_row][wr_col], then wr_col increments; on wrap, wr_row increments.
  - On accepting element (R-1, C-1): set full[w_sel], toggle w_sel, clear both counters.
  - ready_in = !full[w_sel].
- Read side:
  - Counters rd_col (outer, 0..C-1) and rd_row (inner, 0..R-1).
  - valid_out = full[r_sel]. data_out = bank[r_sel][rd_row][rd_col].
  - On valid_out && ready_out, rd_row increments; on wrap, rd_col increments.
  - last_out = valid_out && rd_row==R-1 && rd_col==C-1.
  - When the last element is accepted: clear full[r_sel], toggle r_sel, clear counters.
- Masking: data_out and last_out are forced to 0 whenever valid_out is 0.
- Simultaneous write-complete and read-complete: both are legal in the same cycle and always target different banks. Both flag updates take effect; neither is lost.
- w_sel == r_sel occurs only when both banks are empty or both are full. This is legal.
- Backpressure: while valid_out && !ready_out, data_out and last_out hold stable.
- valid_in while ready_in is 0 is ignored; no state changes.
- Reset mid-operation:
  - Any partially written or partially read matrix is discarded.
  - All flags, selects and counters are cleared.
  - Bank contents are cleared to 0.

## Timing
- Reset values: ready_in 0 while rst is high, 1 in the first cycle after release. valid_out 0, data_out 0, last_out 0, mat_count 0.
- Latency: the first output element is valid in the cycle after the last input element of that matrix is accepted.
- Throughput: 1 element/cycle sustained with both sides continuously ready. Input is never stalled in steady state.
- Both banks full: ready_in stays low until the first read-complete edge. It is high in the following cycle.
- valid_out, data_out and last_out are driven from registers plus read mux only; there is no combinational path from valid_in to valid_out.
- ready_in depends only on registers; there is no combinational path from ready_out to ready_in.

## Configuration
- XPOSE_COUNT_EN defined:
  - Port mat_count exists.
  - It increments by 1 on each accepted last_out beat and wraps from 65535 to 0.
  - It resets to 0.
- Undefined: port mat_count and its counter are absent. All other behaviour is identical.

## Test plan
- R=2, C=3, both sides always ready; input 1,2,3,4,5,6.
  - Output 1,4,2,5,3,6.
  - last_out only on 6.
  - valid_out first rises the cycle after 6 is accepted.
- Back-to-back matrices 1..6 then 11..16, ready_out always 1.
  - No input stall.
  - Output 1,4,2,5,3,6,11,14,12,15,13,16.
- ready_out held 0, three matrices offered.
  - ready_in drops after the 12th accepted element.
  - The third matrix is blocked.
  - Releasing ready_out drains the first matrix.
  - ready_in reasserts after that drain completes.
- ready_out toggling 1,0,1,0 during drain.
  - data_out holds stable on every stalled cycle.
  - Sequence is unchanged.
- Assert rst after 3 of 6 inputs.
  - All outputs go to reset values immediately.
  - The next matrix 7..12 emerges as 7,10,8,11,9,12.
- With XPOSE_COUNT_EN: preload mat_count to 65535 by force, then drain one matrix.
  - mat_count reads 0 after the last beat.
